// File: rtl/vending_pkg.sv
// Shared definitions for the vending payout logic: coin codes, coin values,
// controller state encoding and default stock depth.
package vending_pkg;

  localparam int DEFAULT_INIT_STOCK = 8;
  localparam int NUM_DENOMS         = 4;

  typedef enum logic [1:0] {
    DENOM_1  = 2'd0,
    DENOM_5  = 2'd1,
    DENOM_10 = 2'd2,
    DENOM_50 = 2'd3
  } denom_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TICKET = 3'd1,
    ST_SELECT = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_DONE   = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  function automatic logic [7:0] coin_value(input logic [1:0] code);
    logic [7:0] value;
    case (code)
      DENOM_50: value = 8'd50;
      DENOM_10: value = 8'd10;
      DENOM_5:  value = 8'd5;
      default:  value = 8'd1;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/coin_stock.sv
// Per-denomination coin stock counters plus the greedy selector that names the
// largest in-stock coin not exceeding the amount still owed.
module coin_stock
  import vending_pkg::*;
#(
  parameter int INIT_STOCK = DEFAULT_INIT_STOCK,
  parameter int STOCK_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dec_en,
  input  logic [1:0] dec_denom,
  input  logic       refill,
  input  logic [1:0] refill_denom,
  input  logic [7:0] amount,
  output logic       best_valid,
  output logic [1:0] best_denom
);

  logic [NUM_DENOMS-1:0] w_elig;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DENOMS; gi++) begin : g_denom
      logic [STOCK_W-1:0] r_count;
      logic               w_dec;
      logic               w_inc;

      assign w_dec = dec_en && (dec_denom == 2'(gi));
      assign w_inc = refill && (refill_denom == 2'(gi));

      // A refill and a payout of the same coin in one cycle cancel out.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_count <= STOCK_W'(INIT_STOCK);
        end else if (w_inc && !w_dec) begin
          if (r_count != {STOCK_W{1'b1}}) begin
            r_count <= r_count + 1'b1;
          end
        end else if (w_dec && !w_inc) begin
          if (r_count != '0) begin
            r_count <= r_count - 1'b1;
          end
        end
      end

      assign w_elig[gi] = (r_count != '0) && (coin_value(2'(gi)) <= amount);
    end
  endgenerate

  // Ascending scan: the highest eligible code is the last one written.
  always_comb begin
    best_valid = 1'b0;
    best_denom = 2'd0;
    for (int i = 0; i < NUM_DENOMS; i++) begin
      if (w_elig[i]) begin
        best_valid = 1'b1;
        best_denom = 2'(i);
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Ticket and change payout controller: issues tickets, then pays the change
// greedily one coin at a time, faulting when stock cannot make exact change.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int INIT_STOCK = DEFAULT_INIT_STOCK,
  parameter int STOCK_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] change_amt,
  input  logic [2:0] ticket_num,
  input  logic       ticket_ack,
  input  logic       coin_ack,
  input  logic       refill,
  input  logic [1:0] refill_denom,
  input  logic       clear_fault,
  output logic       busy,
  output logic       ticket_valid,
  output logic       coin_valid,
  output logic [1:0] coin_denom,
  output logic       done,
  output logic       short_fault,
  output logic [7:0] remaining
);

  state_t     r_state;
  logic [7:0] r_remaining;
  logic [2:0] r_tickets;
  logic [1:0] r_denom;

  state_t     w_state_next;
  logic [7:0] w_remaining_next;
  logic [2:0] w_tickets_next;
  logic [1:0] w_denom_next;
  logic       w_coin_taken;
  logic       w_best_valid;
  logic [1:0] w_best_denom;

  coin_stock #(
    .INIT_STOCK (INIT_STOCK),
    .STOCK_W    (STOCK_W)
  ) u_stock (
    .clk          (clk),
    .reset        (reset),
    .dec_en       (w_coin_taken),
    .dec_denom    (r_denom),
    .refill       (refill),
    .refill_denom (refill_denom),
    .amount       (r_remaining),
    .best_valid   (w_best_valid),
    .best_denom   (w_best_denom)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_remaining <= 8'd0;
      r_tickets   <= 3'd0;
      r_denom     <= 2'd0;
    end else begin
      r_state     <= w_state_next;
      r_remaining <= w_remaining_next;
      r_tickets   <= w_tickets_next;
      r_denom     <= w_denom_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_remaining_next = r_remaining;
    w_tickets_next   = r_tickets;
    w_denom_next     = r_denom;
    w_coin_taken     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_remaining_next = change_amt;
          w_tickets_next   = ticket_num;
          w_state_next     = (ticket_num != 3'd0) ? ST_TICKET : ST_SELECT;
        end
      end
      ST_TICKET: begin
        if (ticket_ack) begin
          if (r_tickets <= 3'd1) begin
            w_tickets_next = 3'd0;
            w_state_next   = ST_SELECT;
          end else begin
            w_tickets_next = r_tickets - 3'd1;
          end
        end
      end
      ST_SELECT: begin
        if (r_remaining == 8'd0) begin
          w_state_next = ST_DONE;
        end else if (w_best_valid) begin
          w_denom_next = w_best_denom;
          w_state_next = ST_ISSUE;
        end else begin
          w_state_next = ST_FAULT;
        end
      end
      ST_ISSUE: begin
        // The selector guaranteed the coin fits, so this cannot underflow.
        if (coin_ack) begin
          w_coin_taken     = 1'b1;
          w_remaining_next = r_remaining - coin_value(r_denom);
          w_state_next     = ST_SELECT;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      ST_FAULT: begin
        if (clear_fault) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign busy         = (r_state != ST_IDLE);
  assign ticket_valid = (r_state == ST_TICKET);
  assign coin_valid   = (r_state == ST_ISSUE);
  assign coin_denom   = r_denom;
  assign done         = (r_state == ST_DONE);
  assign short_fault  = (r_state == ST_FAULT);
  assign remaining    = r_remaining;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: ticket handshakes, greedy payout,
// stock exhaustion, fault recovery, delayed acks and mid-transaction reset.
module tb_change_dispenser;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] change_amt;
  logic [2:0] ticket_num;
  logic       ticket_ack;
  logic       coin_ack;
  logic       refill;
  logic [1:0] refill_denom;
  logic       clear_fault;
  logic       busy;
  logic       ticket_valid;
  logic       coin_valid;
  logic [1:0] coin_denom;
  logic       done;
  logic       short_fault;
  logic [7:0] remaining;

  int n_checks;
  int n_fail;
  int n_tickets;
  int coins[$];
  bit saw_done;
  bit saw_fault;

  change_dispenser #(
    .INIT_STOCK (8),
    .STOCK_W    (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .change_amt   (change_amt),
    .ticket_num   (ticket_num),
    .ticket_ack   (ticket_ack),
    .coin_ack     (coin_ack),
    .refill       (refill),
    .refill_denom (refill_denom),
    .clear_fault  (clear_fault),
    .busy         (busy),
    .ticket_valid (ticket_valid),
    .coin_valid   (coin_valid),
    .coin_denom   (coin_denom),
    .done         (done),
    .short_fault  (short_fault),
    .remaining    (remaining)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_value(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int stock_of(input int d);
    int v;
    case (d)
      0:       v = int'(dut.u_stock.g_denom[0].r_count);
      1:       v = int'(dut.u_stock.g_denom[1].r_count);
      2:       v = int'(dut.u_stock.g_denom[2].r_count);
      default: v = int'(dut.u_stock.g_denom[3].r_count);
    endcase
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    clear_fault = 1'b0;
    refill = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Pulse start and follow the transaction until done, fault or cycle budget.
  task automatic run_txn(input int amt, input int nt, input int max_cycles);
    change_amt = 8'(amt);
    ticket_num = 3'(nt);
    start = 1'b1;
    tick();
    start = 1'b0;
    n_tickets = 0;
    coins.delete();
    saw_done = 1'b0;
    saw_fault = 1'b0;
    for (int c = 0; c < max_cycles; c++) begin
      if (ticket_valid && ticket_ack) n_tickets++;
      if (coin_valid && coin_ack) coins.push_back(int'(coin_denom));
      if (done) begin
        saw_done = 1'b1;
        break;
      end
      if (short_fault) begin
        saw_fault = 1'b1;
        break;
      end
      tick();
    end
    $display("txn amt=%0d tickets=%0d -> issued_tickets=%0d coins=%0d done=%0d fault=%0d rem=%0d",
             amt, nt, n_tickets, coins.size(), saw_done, saw_fault, int'(remaining));
    if (saw_done) tick();
  endtask

  initial begin
    int exp_coins[5];
    int active;
    n_checks = 0;
    n_fail = 0;
    reset = 1'b0;
    start = 1'b0;
    change_amt = 8'd0;
    ticket_num = 3'd0;
    ticket_ack = 1'b0;
    coin_ack = 1'b0;
    refill = 1'b0;
    refill_denom = 2'd0;
    clear_fault = 1'b0;

    // Reset values
    do_reset();
    check_value("rst_busy", int'(busy), 0);
    check_value("rst_tvalid", int'(ticket_valid), 0);
    check_value("rst_cvalid", int'(coin_valid), 0);
    check_value("rst_denom", int'(coin_denom), 0);
    check_value("rst_done", int'(done), 0);
    check_value("rst_fault", int'(short_fault), 0);
    check_value("rst_rem", int'(remaining), 0);
    for (int d = 0; d < 4; d++) check_value("rst_stock", stock_of(d), 8);

    // 67 dollars, two tickets, immediate acks
    ticket_ack = 1'b1;
    coin_ack = 1'b1;
    run_txn(67, 2, 60);
    exp_coins = '{3, 2, 1, 0, 0};
    check_value("t67_done", int'(saw_done), 1);
    check_value("t67_tickets", n_tickets, 2);
    check_value("t67_ncoins", coins.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < coins.size()) check_value("t67_coin", coins[i], exp_coins[i]);
    end
    check_value("t67_rem", int'(remaining), 0);
    check_value("t67_stock0", stock_of(0), 6);
    check_value("t67_stock1", stock_of(1), 7);
    check_value("t67_stock2", stock_of(2), 7);
    check_value("t67_stock3", stock_of(3), 7);

    // Zero change, zero tickets: SELECT, then DONE, then IDLE
    change_amt = 8'd0;
    ticket_num = 3'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_value("z_busy_sel", int'(busy), 1);
    check_value("z_done_sel", int'(done), 0);
    check_value("z_cvalid_sel", int'(coin_valid), 0);
    tick();
    check_value("z_done", int'(done), 1);
    tick();
    check_value("z_done_after", int'(done), 0);
    check_value("z_busy_after", int'(busy), 0);

    // Empty the 50s, then 60 must come out as six 10s
    do_reset();
    for (int k = 0; k < 8; k++) begin
      run_txn(50, 0, 20);
      check_value("drain50_done", int'(saw_done), 1);
      check_value("drain50_n", coins.size(), 1);
      if (coins.size() > 0) check_value("drain50_coin", coins[0], 3);
    end
    check_value("drain50_stock", stock_of(3), 0);
    run_txn(60, 0, 60);
    check_value("t60_done", int'(saw_done), 1);
    check_value("t60_ncoins", coins.size(), 6);
    foreach (coins[i]) check_value("t60_coin", coins[i], 2);
    check_value("t60_stock2", stock_of(2), 2);

    // Empty the 5s and 1s, then 3 dollars faults
    do_reset();
    for (int k = 0; k < 8; k++) begin
      run_txn(6, 0, 20);
      check_value("drain6_done", int'(saw_done), 1);
      check_value("drain6_n", coins.size(), 2);
    end
    check_value("drain6_stock0", stock_of(0), 0);
    check_value("drain6_stock1", stock_of(1), 0);
    run_txn(3, 0, 20);
    check_value("f3_fault_seen", int'(saw_fault), 1);
    check_value("f3_ncoins", coins.size(), 0);
    tick();
    tick();
    check_value("f3_short", int'(short_fault), 1);
    check_value("f3_rem", int'(remaining), 3);
    check_value("f3_busy", int'(busy), 1);
    check_value("f3_cvalid", int'(coin_valid), 0);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    check_value("f3_clr_short", int'(short_fault), 0);
    check_value("f3_clr_busy", int'(busy), 0);
    refill = 1'b1;
    refill_denom = 2'd0;
    tick();
    refill = 1'b0;
    check_value("refill_stock0", stock_of(0), 1);

    // Delayed coin_ack with start pulsed meanwhile; refill coincides with the ack
    do_reset();
    coin_ack = 1'b0;
    change_amt = 8'd10;
    ticket_num = 3'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      check_value("hold_cvalid", int'(coin_valid), 1);
      check_value("hold_denom", int'(coin_denom), 2);
      check_value("hold_rem", int'(remaining), 10);
      check_value("hold_tvalid", int'(ticket_valid), 0);
      if (k == 1) begin
        start = 1'b1;
        change_amt = 8'd99;
        ticket_num = 3'd3;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check_value("hold_cvalid_end", int'(coin_valid), 1);
    check_value("hold_rem_end", int'(remaining), 10);
    coin_ack = 1'b1;
    refill = 1'b1;
    refill_denom = 2'd2;
    tick();
    coin_ack = 1'b0;
    refill = 1'b0;
    check_value("ack_cvalid", int'(coin_valid), 0);
    check_value("ack_rem", int'(remaining), 0);
    check_value("ack_refill_stock2", stock_of(2), 8);
    tick();
    check_value("ack_done", int'(done), 1);
    tick();
    check_value("ack_idle_busy", int'(busy), 0);
    check_value("ack_idle_rem", int'(remaining), 0);
    $display("txn delayed-ack amt=10 -> rem=%0d stock10=%0d", int'(remaining), stock_of(2));

    // Reset in ISSUE while the coin is being acknowledged
    coin_ack = 1'b1;
    run_txn(1, 0, 20);
    check_value("pre_rst_stock0", stock_of(0), 7);
    coin_ack = 1'b0;
    change_amt = 8'd50;
    ticket_num = 3'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_value("mid_cvalid", int'(coin_valid), 1);
    reset = 1'b1;
    coin_ack = 1'b1;
    tick();
    reset = 1'b0;
    coin_ack = 1'b0;
    check_value("mid_rst_busy", int'(busy), 0);
    check_value("mid_rst_cvalid", int'(coin_valid), 0);
    check_value("mid_rst_denom", int'(coin_denom), 0);
    check_value("mid_rst_done", int'(done), 0);
    check_value("mid_rst_fault", int'(short_fault), 0);
    check_value("mid_rst_rem", int'(remaining), 0);
    for (int d = 0; d < 4; d++) check_value("mid_rst_stock", stock_of(d), 8);
    active = 0;
    coin_ack = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (coin_valid || ticket_valid || busy) active++;
      tick();
    end
    coin_ack = 1'b0;
    check_value("post_rst_quiet", active, 0);
    $display("txn reset-in-issue -> active_cycles=%0d", active);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The block SHALL have parameter INIT_STOCK, default 8, the per-denomination coin count loaded at reset.
REQ-002 The block SHALL have parameter STOCK_W, default 8, the width of each stock counter.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to pay out; sampled only in IDLE.
REQ-006 change_amt  in  8  change owed in dollars; latched on accepted start.
REQ-007 ticket_num  in  3  tickets to issue; latched on accepted start.
REQ-008 ticket_ack  in  1  ticket mechanism has taken the offered ticket.
REQ-009 coin_ack  in  1  coin mechanism has taken the offered coin.
REQ-010 refill  in  1  one-cycle pulse: add one coin of refill_denom to stock.
REQ-011 refill_denom  in  2  denomination code for refill.
REQ-012 clear_fault  in  1  leave FAULT and return to IDLE.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 ticket_valid  out  1  a ticket is offered.
REQ-015 coin_valid  out  1  a coin is offered.
REQ-016 coin_denom  out  2  code of the offered coin: 3=50, 2=10, 1=5, 0=1 dollars.
REQ-017 done  out  1  one-cycle pulse: the transaction completed fully.
REQ-018 short_fault  out  1  stock cannot make exact change; held high while in FAULT.
REQ-019 remaining  out  8  change still owed.

Function
REQ-020 States SHALL be IDLE, TICKET, SELECT, ISSUE, DONE and FAULT.
REQ-021 In IDLE, start=1 SHALL latch change_amt into remaining and ticket_num into a ticket counter, then go to TICKET if ticket_num>0, else to SELECT; busy is high from the next cycle.
REQ-022 start SHALL be ignored in every state other than IDLE.
REQ-023 In TICKET, ticket_valid SHALL be held high until ticket_ack; each ack decrements the ticket counter, and the ack of the last ticket moves to SELECT.
REQ-024 SELECT SHALL last one cycle and go:
- to DONE if remaining==0;
- otherwise to ISSUE with the largest denomination that is <= remaining and has stock>0;
- otherwise to FAULT.
REQ-025 In ISSUE, coin_valid SHALL be high, and coin_denom SHALL stay stable until coin_ack.
REQ-026 On coin_ack, remaining SHALL decrease by the coin value, that denomination's stock SHALL decrement, and the state SHALL return to SELECT (one idle cycle between coins).
REQ-027 done SHALL be high for exactly the DONE cycle; the next state SHALL be IDLE.
REQ-028 In FAULT, short_fault SHALL be high, and remaining SHALL hold the unpaid amount; clear_fault moves to IDLE.
REQ-029 A refill SHALL increment the selected stock counter in any state, saturating at 2^STOCK_W-1.
REQ-030 A refill coinciding with coin_ack of the same denomination SHALL leave that stock unchanged.
REQ-031 ticket_ack outside TICKET and coin_ack outside ISSUE SHALL be ignored.
REQ-032 All arithmetic SHALL be unsigned 8-bit; remaining never underflows because of REQ-024.

Reset
REQ-033 reset SHALL take priority over all inputs and force IDLE.
REQ-034 On reset, the outputs SHALL be busy=0, ticket_valid=0, coin_valid=0, coin_denom=0, done=0, short_fault=0 and remaining=0.
REQ-035 On reset, every stock counter SHALL reload INIT_STOCK.
REQ-036 Reset mid-transaction (including mid-handshake) SHALL abandon the transaction with no further tickets or coins offered.

Structure
REQ-037 Denomination codes, coin values, state encoding and INIT_STOCK default SHALL live in a shared package, vending_pkg, reused by the selling logic.
REQ-038 Stock counters and the greedy denomination selector SHALL be one sub-module, coin_stock, with decrement/refill ports and a combinational best-denomination output.

Verification
REQ-039 Full stock, start with change_amt=67, ticket_num=2, immediate acks -> 2 ticket handshakes, then coins 50,10,5,1,1, done pulse, remaining=0, stocks 7,7,7,6.
REQ-040 start with change_amt=0, ticket_num=0 -> SELECT next cycle, done high the cycle after, busy low the following cycle.
REQ-041 50-dollar stock=0, change_amt=60 -> six 10-dollar coins, then done.
REQ-042 1- and 5-dollar stock=0, change_amt=3 -> FAULT, short_fault=1, remaining=3; clear_fault -> IDLE and short_fault=0.
REQ-043 coin_ack delayed 5 cycles, with start pulsed meanwhile -> coin_valid and coin_denom stable throughout; the start has no effect.
REQ-044 reset asserted during ISSUE -> next cycle all outputs at reset values, stocks=INIT_STOCK, and no coin offered afterwards.
